// File: rtl/mem_bus_ctrl.sv
// MEM-stage bus access sequencer: alignment check, request/grant arbitration and bus cycle control.
// Optional ACCESS timeout abort is compiled in with `define MEM_BUS_TIMEOUT_EN.
module mem_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_as,
  input  logic        ex_rw,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wr_data,
  input  logic        stall,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic        miss_align,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_
`ifdef MEM_BUS_TIMEOUT_EN
  ,
  output logic        bus_err
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

  state_t      state;
  logic [31:0] rd_hold;
  logic        valid;
  logic        done;
  logic        timeout;
  logic        fin;
  logic [31:0] read_val;

  assign miss_align = ex_as & (ex_addr[1:0] != 2'b00);
  assign valid      = ex_as & ~miss_align & ~flush & ~stall;
  assign done       = (state == ACCESS) & ~bus_rdy_;

`ifdef MEM_BUS_TIMEOUT_EN
  logic [7:0] to_cnt;
  // Fires on the TIMEOUT_CYCLES-th not-ready ACCESS cycle (counter starts at 0 on entry).
  assign timeout = (state == ACCESS) & bus_rdy_ & (to_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign bus_err = timeout;
`else
  assign timeout = 1'b0;
`endif

  assign fin      = done | timeout;
  // Writes and flushed reads return zero so nothing stale reaches the MEM register.
  assign read_val = (bus_rw | flush) ? 32'h0 : bus_rd_data;

  always_comb begin
    busy    = 1'b0;
    rd_data = 32'h0;
    case (state)
      IDLE:   busy = valid;
      REQ:    busy = 1'b1;
      ACCESS: begin
        busy = ~fin;
        if (done) rd_data = read_val;
      end
      STALL:  rd_data = rd_hold;
      default: begin
        busy    = 1'b0;
        rd_data = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_addr    <= 30'h0;
      bus_rw      <= 1'b0;
      bus_wr_data <= 32'h0;
      rd_hold     <= 32'h0;
`ifdef MEM_BUS_TIMEOUT_EN
      to_cnt      <= 8'h0;
`endif
    end else begin
      bus_as_ <= 1'b1;
      case (state)
        IDLE: begin
          if (valid) begin
            bus_addr    <= ex_addr[31:2];
            bus_rw      <= ex_rw;
            bus_wr_data <= ex_wr_data;
            bus_req_    <= 1'b0;
            state       <= REQ;
          end
        end
        REQ: begin
          // Grant wins over a same-cycle flush: once granted the bus cycle must run.
          if (!bus_grnt_) begin
            bus_as_ <= 1'b0;
            state   <= ACCESS;
`ifdef MEM_BUS_TIMEOUT_EN
            to_cnt  <= 8'h0;
`endif
          end else if (flush) begin
            bus_req_ <= 1'b1;
            state    <= IDLE;
          end
        end
        ACCESS: begin
`ifdef MEM_BUS_TIMEOUT_EN
          if (bus_rdy_) to_cnt <= to_cnt + 8'h1;
`endif
          if (fin) begin
            bus_req_ <= 1'b1;
            rd_hold  <= done ? read_val : 32'h0;
            state    <= (stall & ~flush) ? STALL : IDLE;
          end
        end
        STALL: begin
          if (!stall || flush) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed vector table, random transactions, multi-cycle corners.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst, ex_as, ex_rw, stall, flush;
  logic [31:0] ex_addr, ex_wr_data, bus_rd_data;
  logic        busy, miss_align, bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
  logic [31:0] rd_data, bus_wr_data;
  logic [29:0] bus_addr;
`ifdef MEM_BUS_TIMEOUT_EN
  logic        bus_err;
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ex_as(ex_as), .ex_rw(ex_rw), .ex_addr(ex_addr),
    .ex_wr_data(ex_wr_data), .stall(stall), .flush(flush), .busy(busy),
    .rd_data(rd_data), .miss_align(miss_align), .bus_req_(bus_req_),
    .bus_grnt_(bus_grnt_), .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
`ifdef MEM_BUS_TIMEOUT_EN
    , .bus_err(bus_err)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wd;
    logic [31:0] rdv;
    int          g, r, s;     // grant delay, ready wait states, extra stall cycles
    int          exp_busy;
    logic        exp_miss;
    logic [29:0] exp_baddr;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: latency and data derived directly from the access rules.
  function automatic vec_t model(input vec_t v);
    vec_t e = v;
    e.exp_miss  = (v.addr % 4) != 0;
    e.exp_busy  = e.exp_miss ? 0 : v.g + v.r + 2;
    e.exp_baddr = 30'(v.addr / 4);
    e.exp_rd    = (e.exp_miss || v.rw) ? 32'h0 : v.rdv;
    return e;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int          busy_n = 0;
    int          ncyc;
    bit          req_ok = 1, as_ok = 1, hold_ok = 1, stall_ok = 1;
    logic [31:0] done_rd = 32'h0;
    ncyc = v.g + v.r + 3;
    @(negedge clk);
    ex_as = 1'b1; ex_rw = v.rw; ex_addr = v.addr; ex_wr_data = v.wd;
    stall = 1'b0; flush = 1'b0; bus_rd_data = v.rdv; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    #1;
    check({tag, "_miss"}, {31'h0, miss_align}, {31'h0, v.exp_miss});
    if (v.exp_miss) begin
      check({tag, "_busy"}, {31'h0, busy}, 32'h0);
      @(negedge clk); ex_as = 1'b0; #1;
      check({tag, "_noreq"}, {31'h0, bus_req_}, 32'h1);
      check({tag, "_noas"}, {31'h0, bus_as_}, 32'h1);
      return;
    end
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(negedge clk);
        ex_as     = 1'b0;
        bus_grnt_ = (c <= v.g);
        bus_rdy_  = (c != ncyc - 1);
        stall     = (c == ncyc - 1) && (v.s > 0);
        #1;
      end
      if (busy === 1'b1) busy_n++;
      if (bus_req_ !== (c == 0)) req_ok = 0;
      if (bus_as_ !== (c != v.g + 2)) as_ok = 0;
      if (c >= v.g + 2 && (bus_addr !== v.exp_baddr || bus_rw !== v.rw || bus_wr_data !== v.wd))
        hold_ok = 0;
      if (c == ncyc - 1) done_rd = rd_data;
    end
    check({tag, "_busy_cycles"}, busy_n, v.exp_busy);
    check({tag, "_req_window"}, {31'h0, req_ok}, 32'h1);
    check({tag, "_as_pulse"}, {31'h0, as_ok}, 32'h1);
    check({tag, "_bus_hold"}, {31'h0, hold_ok}, 32'h1);
    check({tag, "_rd_data"}, done_rd, v.exp_rd);
    if (v.s > 0) begin
      for (int k = 0; k <= v.s; k++) begin
        @(negedge clk);
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; stall = (k < v.s);
        #1;
        if (rd_data !== v.exp_rd || busy !== 1'b0 || bus_req_ !== 1'b1) stall_ok = 0;
      end
      check({tag, "_stall_hold"}, {31'h0, stall_ok}, 32'h1);
    end
    @(negedge clk);
    bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; stall = 1'b0;
    #1;
    check({tag, "_idle_req"}, {31'h0, bus_req_}, 32'h1);
    check({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_idle_rd"}, rd_data, 32'h0);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    tbl[0] = '{32'h0000_0100, 1'b0, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 2, 1'b0, 30'h40,        32'hDEAD_BEEF};
    tbl[1] = '{32'h0000_0104, 1'b1, 32'h1234_5678, 32'hFFFF_0000, 3, 2, 0, 7, 1'b0, 30'h41,        32'h0};
    tbl[2] = '{32'h0000_0102, 1'b0, 32'h0,         32'h5555_5555, 0, 0, 0, 0, 1'b1, 30'h40,        32'h0};
    tbl[3] = '{32'h0000_0108, 1'b0, 32'h0,         32'hA5A5_A5A5, 0, 0, 3, 2, 1'b0, 30'h42,        32'hA5A5_A5A5};
    tbl[4] = '{32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0BAD_F00D, 1, 1, 1, 4, 1'b0, 30'h3FFF_FFFF, 32'h0BAD_F00D};
    tbl[5] = '{32'h0000_0003, 1'b1, 32'h7777_7777, 32'h0,         0, 0, 0, 0, 1'b1, 30'h0,         32'h0};
    tbl[6] = '{32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h1357_9BDF, 0, 3, 2, 5, 1'b0, 30'h0,         32'h0};

    rst = 1'b1; ex_as = 1'b0; ex_rw = 1'b0; ex_addr = 32'h0; ex_wr_data = 32'h0;
    stall = 1'b0; flush = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_req", {31'h0, bus_req_}, 32'h1);
    check("rst_as", {31'h0, bus_as_}, 32'h1);
    check("rst_addr", {2'b0, bus_addr}, 32'h0);
    check("rst_rw", {31'h0, bus_rw}, 32'h0);
    check("rst_wdata", bus_wr_data, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rd", rd_data, 32'h0);

    for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      rv.addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) rv.addr = rv.addr | 32'($urandom_range(1, 3));
      rv.rw  = 1'($urandom_range(0, 1));
      rv.wd  = $urandom;
      rv.rdv = $urandom;
      rv.g   = $urandom_range(0, 3);
      rv.r   = $urandom_range(0, 3);
      rv.s   = $urandom_range(0, 2);
      run_txn(model(rv), $sformatf("rnd%0d", i));
    end

    // Flush while waiting for grant: request withdrawn, no strobe.
    begin
      bit as_seen = 0;
      @(negedge clk); ex_as = 1'b1; ex_rw = 1'b0; ex_addr = 32'h300; bus_grnt_ = 1'b1; #1;
      @(negedge clk); ex_as = 1'b0; flush = 1'b1; #1;
      check("freq_busy", {31'h0, busy}, 32'h1);
      check("freq_req_held", {31'h0, bus_req_}, 32'h0);
      @(negedge clk); flush = 1'b0; bus_grnt_ = 1'b0; #1;
      check("freq_req_rel", {31'h0, bus_req_}, 32'h1);
      for (int k = 0; k < 3; k++) begin
        if (bus_as_ !== 1'b1) as_seen = 1;
        @(negedge clk); #1;
      end
      check("freq_no_as", {31'h0, as_seen}, 32'h0);
      bus_grnt_ = 1'b1;
    end

    // Flush during ACCESS: cycle completes, then IDLE even with stall asserted.
    @(negedge clk); ex_as = 1'b1; ex_rw = 1'b0; ex_addr = 32'h400; bus_rd_data = 32'h1111_2222; #1;
    @(negedge clk); ex_as = 1'b0; bus_grnt_ = 1'b0; #1;
    @(negedge clk); bus_grnt_ = 1'b1; flush = 1'b1; #1;
    check("facc_busy_wait", {31'h0, busy}, 32'h1);
    @(negedge clk); flush = 1'b0; #1;
    check("facc_not_aborted", {31'h0, bus_req_}, 32'h0);
    @(negedge clk); bus_rdy_ = 1'b0; flush = 1'b1; stall = 1'b1; #1;
    check("facc_done_busy", {31'h0, busy}, 32'h0);
    @(negedge clk); bus_rdy_ = 1'b1; flush = 1'b0; stall = 1'b0; ex_as = 1'b1; ex_addr = 32'h404; #1;
    check("facc_idle_req", {31'h0, bus_req_}, 32'h1);
    check("facc_idle_accepts", {31'h0, busy}, 32'h1);
    @(negedge clk); ex_as = 1'b0; bus_grnt_ = 1'b0; #1;
    @(negedge clk); bus_rdy_ = 1'b0; #1;
    @(negedge clk); bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; #1;
    check("facc_drain_req", {31'h0, bus_req_}, 32'h1);

    // Reset in the middle of ACCESS releases the bus on the next edge.
    @(negedge clk); ex_as = 1'b1; ex_rw = 1'b1; ex_addr = 32'h500; ex_wr_data = 32'hCAFE_F00D; #1;
    @(negedge clk); ex_as = 1'b0; bus_grnt_ = 1'b0; #1;
    @(negedge clk); bus_grnt_ = 1'b1; #1;
    check("rsta_addr_pre", {2'b0, bus_addr}, 32'h140);
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; #1;
    check("rsta_req", {31'h0, bus_req_}, 32'h1);
    check("rsta_busy", {31'h0, busy}, 32'h0);
    check("rsta_as", {31'h0, bus_as_}, 32'h1);
    check("rsta_addr", {2'b0, bus_addr}, 32'h0);
    check("rsta_wdata", bus_wr_data, 32'h0);

`ifdef MEM_BUS_TIMEOUT_EN
    // Slave never ready: abort on the TO-th ACCESS cycle.
    begin
      int err_at = -1;
      logic busy_at = 1'b1;
      @(negedge clk); ex_as = 1'b1; ex_rw = 1'b0; ex_addr = 32'h600; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; #1;
      for (int c = 1; c <= TO + 1; c++) begin
        @(negedge clk); ex_as = 1'b0; bus_grnt_ = 1'b0; #1;
        if (bus_err === 1'b1 && err_at < 0) err_at = c;
        if (c == TO + 1) busy_at = busy;
      end
      check("to_err_cycle", err_at, TO + 1);
      check("to_busy", {31'h0, busy_at}, 32'h0);
      @(negedge clk); bus_grnt_ = 1'b1; #1;
      check("to_req_rel", {31'h0, bus_req_}, 32'h1);
      check("to_err_pulse", {31'h0, bus_err}, 32'h0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
